uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
Sequencing controller between the UART interface (RX/TX FIFOs) and the combinational ALU. Pops a 3-byte frame from the RX FIFO (operand A, operand B, opcode) and drives the ALU operand/opcode registers. Captures the ALU result and pushes it into the TX FIFO. Includes an inter-byte timeout that discards partial frames, and rejects unknown opcodes by transmitting an error code.

Parameters:
NB_DATA, 8, width of UART bytes, ALU operands and result
NB_OP, 6, width of ALU opcode (low bits of third frame byte)
TIMEOUT, 100000, max clocks between consecutive frame bytes before the frame is discarded
NB_TIMEOUT, 17, width of timeout counter (must hold TIMEOUT)
ERR_CODE, 8'hFF, byte transmitted in place of a result when the opcode is invalid

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous reset, active-low
i_rx_empty  input  1  RX FIFO empty flag
i_rx_data  input  NB_DATA  RX FIFO head data (valid when i_rx_empty=0)
i_tx_full  input  1  TX FIFO full flag
i_alu_result  input  NB_DATA  combinational ALU result for current o_alu_* values
o_rd_uart  output  1  one-cycle pop strobe to RX FIFO
o_wr_uart  output  1  one-cycle push strobe to TX FIFO
o_tx_data  output  NB_DATA  byte to push (valid with o_wr_uart)
o_alu_a  output  NB_DATA  registered operand A
o_alu_b  output  NB_DATA  registered operand B
o_alu_op  output  NB_OP  registered opcode
o_busy  output  1  high in any state other than WAIT_A
o_frame_error  output  1  one-cycle pulse when a partial frame is discarded on timeout

Behaviour:
- Reset (i_reset=0, async): state=WAIT_A; all outputs 0; timeout counter 0. Reset mid-frame discards the frame with no TX push.
- FIFO contract: head data is readable while not empty; pop takes effect at the clock edge where o_rd_uart=1, and flags are valid the following cycle. The controller never asserts o_rd_uart while i_rx_empty=1 and never asserts o_wr_uart while i_tx_full=1.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A: if !i_rx_empty, register i_rx_data->o_alu_a, pulse o_rd_uart, go to WAIT_B. No timeout in this state.
- WAIT_B: if !i_rx_empty, register i_rx_data->o_alu_b, pulse o_rd_uart, go to WAIT_OP.
- WAIT_OP: if !i_rx_empty, register i_rx_data[NB_OP-1:0]->o_alu_op, pulse o_rd_uart, and set an internal op_valid flag. Go to EXEC. Upper byte bits are ignored.
- Valid opcodes: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02. Any other value is invalid.
- EXEC (exactly 1 cycle): o_alu_* are stable here. Capture result = op_valid ? i_alu_result : ERR_CODE into an internal register, then go to SEND.
- SEND: wait while i_tx_full=1, holding state and data. When i_tx_full=0, assert o_wr_uart for one cycle with o_tx_data=result, then go to WAIT_A.
- Throughput: minimum 5 cycles per frame (3 pops, EXEC, push) if the RX FIFO holds bytes back-to-back.
- o_alu_a/b/op keep their last values after SEND until overwritten.
- o_tx_data is registered and changes only on entry to SEND.
- Timeout: the counter clears on every pop and on entry to WAIT_A. It increments each cycle in WAIT_B/WAIT_OP while i_rx_empty=1. On reaching TIMEOUT-1 with the FIFO still empty: pulse o_frame_error, go to WAIT_A, no push.
- A byte arriving in the same cycle the counter hits TIMEOUT-1 wins: pop it and do not time out.
- EXEC and SEND have no timeout. TX backpressure may stall SEND indefinitely, and RX bytes accumulate in the FIFO meanwhile.
- The RX FIFO overflow policy belongs to the FIFO; this block is unaware of it.

Test Plan:
- Frame 0x05, 0x03, 0x20 in RX FIFO, TX not full -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20. One o_wr_uart pulse with o_tx_data=ALU result (0x08 with reference ALU), 5 cycles after first pop; o_busy high from 1st pop through push.
- Frame 0x0A, 0x0F, 0x3F (invalid op) -> o_wr_uart pulse with o_tx_data=0xFF; no o_frame_error.
- TIMEOUT=20 override; push 0x11, 0x22 only -> o_frame_error pulses once 20 cycles after the 2nd pop, state WAIT_A, no TX push. A following full frame 0x01, 0x01, 0x22 -> pushes SUB result 0x00.
- Frame 0x80, 0x02, 0x03 with i_tx_full=1 for 50 cycles -> controller holds in SEND with o_wr_uart=0. Push occurs the first cycle after i_tx_full drops, o_tx_data=0xE0 (SRA).
- Two frames queued back-to-back (0x01, 0x02, 0x20, 0x07, 0x01, 0x22) -> exactly 6 pops and 2 pushes (0x03 then 0x06), never a pop with i_rx_empty=1.
- Assert i_reset low while in WAIT_OP -> all outputs 0 immediately (async). After release, bytes remaining in the FIFO are parsed as a new frame starting at operand A.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl
// Purpose  : pops a 3-byte frame (A, B, opcode) from the RX FIFO, runs it
//            through the external ALU and pushes the result to the TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl #(
  parameter int                 NB_DATA    = 8,
  parameter int                 NB_OP      = 6,
  parameter int                 TIMEOUT    = 100000,
  parameter int                 NB_TIMEOUT = 17,
  parameter logic [NB_DATA-1:0] ERR_CODE   = 8'hFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_full,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_rd_uart,
  output logic               o_wr_uart,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_busy,
  output logic               o_frame_error
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] c_TO_LAST = NB_TIMEOUT'(TIMEOUT - 1);
  localparam logic [NB_OP-1:0]      c_OP_ADD  = NB_OP'('h20);
  localparam logic [NB_OP-1:0]      c_OP_SUB  = NB_OP'('h22);
  localparam logic [NB_OP-1:0]      c_OP_AND  = NB_OP'('h24);
  localparam logic [NB_OP-1:0]      c_OP_OR   = NB_OP'('h25);
  localparam logic [NB_OP-1:0]      c_OP_XOR  = NB_OP'('h26);
  localparam logic [NB_OP-1:0]      c_OP_NOR  = NB_OP'('h27);
  localparam logic [NB_OP-1:0]      c_OP_SRA  = NB_OP'('h03);
  localparam logic [NB_OP-1:0]      c_OP_SRL  = NB_OP'('h02);

  state_t                  r_state;
  state_t                  w_next;
  logic [NB_TIMEOUT-1:0]   r_cnt;
  logic                    r_armed;
  logic                    r_op_valid;
  logic [NB_DATA-1:0]      r_alu_a;
  logic [NB_DATA-1:0]      r_alu_b;
  logic [NB_OP-1:0]        r_alu_op;
  logic [NB_DATA-1:0]      r_tx_data;
  logic                    w_rd;
  logic                    w_wr;
  logic                    w_ferr;
  logic                    w_cnt_clr;
  logic                    w_cnt_inc;
  logic                    w_op_ok;
  logic [NB_OP-1:0]        w_op_byte;

  assign w_op_byte = i_rx_data[NB_OP-1:0];

  always_comb begin
    w_op_ok = 1'b0;
    case (w_op_byte)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
      c_OP_XOR, c_OP_NOR, c_OP_SRA, c_OP_SRL: w_op_ok = 1'b1;
      default:                                w_op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_WAIT_A;
    end else begin
      r_state <= w_next;
    end
  end

  // r_armed keeps the pop strobe low while reset is held, even with bytes queued.
  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_ferr    = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      S_WAIT_A: begin
        w_cnt_clr = 1'b1;
        if (!i_rx_empty && r_armed) begin
          w_rd   = 1'b1;
          w_next = S_WAIT_B;
        end
      end
      S_WAIT_B, S_WAIT_OP: begin
        if (!i_rx_empty) begin
          w_rd      = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = (r_state == S_WAIT_B) ? S_WAIT_OP : S_EXEC;
        end else if (r_cnt == c_TO_LAST) begin
          w_ferr    = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_WAIT_A;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_EXEC: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        if (!i_tx_full) begin
          w_wr   = 1'b1;
          w_next = S_WAIT_A;
        end
      end
      default: begin
        w_next = S_WAIT_A;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_op_valid <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + NB_TIMEOUT'(1);
      end
      if (w_rd && (r_state == S_WAIT_A)) begin
        r_alu_a <= i_rx_data;
      end
      if (w_rd && (r_state == S_WAIT_B)) begin
        r_alu_b <= i_rx_data;
      end
      if (w_rd && (r_state == S_WAIT_OP)) begin
        r_alu_op   <= w_op_byte;
        r_op_valid <= w_op_ok;
      end
      if (r_state == S_EXEC) begin
        r_tx_data <= r_op_valid ? i_alu_result : ERR_CODE;
      end
    end
  end

  assign o_rd_uart     = w_rd;
  assign o_wr_uart     = w_wr;
  assign o_frame_error = w_ferr;
  assign o_tx_data     = r_tx_data;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_busy        = (r_state != S_WAIT_A);

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// Directed testbench for uart_alu_ctrl: FIFO/ALU models around the DUT,
// hand-computed expectations checked inline per scenario task.
module tb_uart_alu_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       tx_full;
  logic [7:0] alu_result;
  logic       rd_uart;
  logic       wr_uart;
  logic [7:0] tx_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       busy;
  logic       frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pops = 0;
  int         pushes = 0;
  int         bad_pops = 0;
  int         bad_pushes = 0;
  int         ferr_count = 0;

  uart_alu_ctrl #(
    .NB_DATA   (8),
    .NB_OP     (6),
    .TIMEOUT   (20),
    .NB_TIMEOUT(17),
    .ERR_CODE  (8'hFF)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_rx_empty   (rx_empty),
    .i_rx_data    (rx_data),
    .i_tx_full    (tx_full),
    .i_alu_result (alu_result),
    .o_rd_uart    (rd_uart),
    .o_wr_uart    (wr_uart),
    .o_tx_data    (tx_data),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_busy       (busy),
    .o_frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_data  = fifo_mem[rd_ptr[3:0]];

  // Reference ALU
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h26:   alu_result = alu_a ^ alu_b;
      6'h27:   alu_result = ~(alu_a | alu_b);
      6'h03:   alu_result = $signed(alu_a) >>> alu_b;
      6'h02:   alu_result = alu_a >> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (rd_uart) begin
      pops <= pops + 1;
      if (rd_ptr == wr_ptr) bad_pops <= bad_pops + 1;
      else                  rd_ptr   <= rd_ptr + 1;
    end
    if (wr_uart) begin
      pushes <= pushes + 1;
      if (tx_full) bad_pushes <= bad_pushes + 1;
    end
    if (frame_error) ferr_count <= ferr_count + 1;
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_wr(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (wr_uart) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tx_full = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rd_uart, wr_uart, busy, frame_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000", {rd_uart, wr_uart, busy, frame_error});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op, tx_data} !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_data: got a=%h b=%h op=%h tx=%h expected all 0", alu_a, alu_b, alu_op, tx_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add();
    push_byte(8'h05); push_byte(8'h03); push_byte(8'h20);
    #1;
    n_checks++;
    if (rd_uart !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_pop_a: got rd=%b busy=%b expected rd=1 busy=0", rd_uart, busy);
    end
    @(negedge clk);
    n_checks++;
    if (rd_uart !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_pop_b: got rd=%b busy=%b expected rd=1 busy=1", rd_uart, busy);
    end
    @(negedge clk);
    n_checks++;
    if (rd_uart !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_pop_op: got rd=%b busy=%b expected rd=1 busy=1", rd_uart, busy);
    end
    @(negedge clk);
    n_checks++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h20 || rd_uart !== 1'b0 || wr_uart !== 1'b0) begin
      n_fail++;
      $display("FAIL add_exec: got a=%h b=%h op=%h rd=%b wr=%b expected 05 03 20 0 0",
               alu_a, alu_b, alu_op, rd_uart, wr_uart);
    end
    @(negedge clk);
    n_checks++;
    if (wr_uart !== 1'b1 || tx_data !== 8'h08 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_push: got wr=%b tx=%h busy=%b expected 1 08 1", wr_uart, tx_data, busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_uart !== 1'b0 || alu_a !== 8'h05 || alu_op !== 6'h20) begin
      n_fail++;
      $display("FAIL add_idle: got busy=%b wr=%b a=%h op=%h expected 0 0 05 20", busy, wr_uart, alu_a, alu_op);
    end
  endtask

  task automatic test_invalid_op();
    bit seen;
    int ferr0 = ferr_count;
    push_byte(8'h0A); push_byte(8'h0F); push_byte(8'h3F);
    wait_wr(10, seen);
    n_checks++;
    if (seen !== 1'b1 || tx_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL invalid_op_push: got seen=%b tx=%h expected 1 ff", seen, tx_data);
    end
    @(negedge clk);
    n_checks++;
    if (ferr_count !== ferr0) begin
      n_fail++;
      $display("FAIL invalid_op_no_ferr: got %0d frame errors expected %0d", ferr_count, ferr0);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int push0 = pushes;
    int ok_quiet = 1;
    push_byte(8'h11); push_byte(8'h22);
    @(negedge clk);
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      if (frame_error !== 1'b0) ok_quiet = 0;
    end
    n_checks++;
    if (ok_quiet !== 1) begin
      n_fail++;
      $display("FAIL timeout_early: got early frame_error expected none before cycle 20");
    end
    @(negedge clk);
    n_checks++;
    if (frame_error !== 1'b1 || wr_uart !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: got ferr=%b wr=%b expected 1 0", frame_error, wr_uart);
    end
    @(negedge clk);
    n_checks++;
    if (frame_error !== 1'b0 || busy !== 1'b0 || pushes !== push0) begin
      n_fail++;
      $display("FAIL timeout_after: got ferr=%b busy=%b pushes=%0d expected 0 0 %0d",
               frame_error, busy, pushes, push0);
    end
    push_byte(8'h01); push_byte(8'h01); push_byte(8'h22);
    wait_wr(10, seen);
    n_checks++;
    if (seen !== 1'b1 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_next_frame: got seen=%b tx=%h expected 1 00", seen, tx_data);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout_boundary();
    bit seen;
    push_byte(8'h07); push_byte(8'h02);
    @(negedge clk);
    repeat (20) @(negedge clk);
    push_byte(8'h20);
    #1;
    n_checks++;
    if (rd_uart !== 1'b1 || frame_error !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_byte_wins: got rd=%b ferr=%b expected 1 0", rd_uart, frame_error);
    end
    wait_wr(10, seen);
    n_checks++;
    if (seen !== 1'b1 || tx_data !== 8'h09) begin
      n_fail++;
      $display("FAIL boundary_result: got seen=%b tx=%h expected 1 09", seen, tx_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int wr_seen = 0;
    tx_full = 1'b1;
    push_byte(8'h80); push_byte(8'h02); push_byte(8'h03);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_uart !== 1'b0) wr_seen++;
    end
    n_checks++;
    if (wr_seen !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got wr cycles=%0d busy=%b expected 0 1", wr_seen, busy);
    end
    tx_full = 1'b0;
    #1;
    n_checks++;
    if (wr_uart !== 1'b1 || tx_data !== 8'hE0) begin
      n_fail++;
      $display("FAIL bp_release: got wr=%b tx=%h expected 1 e0", wr_uart, tx_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pop0 = pops;
    int push0 = pushes;
    logic [7:0] got [2];
    int n = 0;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h20);
    push_byte(8'h07); push_byte(8'h01); push_byte(8'h22);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (wr_uart && n < 2) begin
        got[n] = tx_data;
        n++;
      end
    end
    n_checks++;
    if (pops - pop0 !== 6 || pushes - push0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_counts: got pops=%0d pushes=%0d expected 6 2", pops - pop0, pushes - push0);
    end
    n_checks++;
    if (n !== 2 || got[0] !== 8'h03 || got[1] !== 8'h06) begin
      n_fail++;
      $display("FAIL b2b_data: got n=%0d %h %h expected 2 03 06", n, got[0], got[1]);
    end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    int push0 = pushes;
    push_byte(8'h04); push_byte(8'h05);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_uart, wr_uart, busy, frame_error} !== 4'b0000 || {alu_a, alu_b, alu_op, tx_data} !== 30'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got strobes=%b a=%h b=%h op=%h tx=%h expected all 0",
               {rd_uart, wr_uart, busy, frame_error}, alu_a, alu_b, alu_op, tx_data);
    end
    push_byte(8'h09); push_byte(8'h03); push_byte(8'h24);
    #1;
    n_checks++;
    if (rd_uart !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_no_pop: got rd=%b expected 0", rd_uart);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (pushes !== push0) begin
      n_fail++;
      $display("FAIL rst_mid_no_push: got pushes=%0d expected %0d", pushes, push0);
    end
    wait_wr(12, seen);
    n_checks++;
    if (seen !== 1'b1 || tx_data !== 8'h01 || alu_a !== 8'h09 || alu_b !== 8'h03) begin
      n_fail++;
      $display("FAIL rst_mid_reparse: got seen=%b tx=%h a=%h b=%h expected 1 01 09 03",
               seen, tx_data, alu_a, alu_b);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_invalid_op();
    test_timeout();
    test_timeout_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    n_checks++;
    if (bad_pops !== 0 || bad_pushes !== 0) begin
      n_fail++;
      $display("FAIL protocol: got pops_on_empty=%0d pushes_on_full=%0d expected 0 0", bad_pops, bad_pushes);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
